// File: rtl/iir_stream_host.sv
// Block buffer host for the IIR filter core: fills a sample block from a stream,
// serves it to the filter, captures results and streams them back out.
module iir_stream_host #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        iir_rst,
  input  logic        load,
  input  logic [19:0] RAddr,
  output logic [15:0] DIn,
  input  logic        WEN,
  input  logic [19:0] WAddr,
  input  logic [15:0] Yn,
  output logic        data_done,
  input  logic        Finish,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = ADDR_W + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LAST_IDX = cnt_t'(DEPTH - 1);
  localparam cnt_t ONE = cnt_t'(1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  cnt_t   fill_cnt_q, fill_cnt_d;
  cnt_t   len_q, len_d;
  cnt_t   rd_ptr_q, rd_ptr_d;
  logic   data_done_q, data_done_d;
  logic   iir_rst_q, iir_rst_d;

  logic [15:0] in_mem [DEPTH];
  logic [15:0] out_mem [DEPTH];

  logic        accept;
  logic        wr_ok;
  logic        last_wr;
  logic        beat;
  logic [19:0] len_w;
  cnt_t        len_m1;

  assign len_w  = 20'(len_q);
  assign len_m1 = len_q - ONE;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  assign wr_ok   = (state_q == SERVE) && WEN && (WAddr < len_w);
  assign last_wr = wr_ok && (WAddr == 20'(len_m1));

  // Out-of-range or idle reads return zero so the filter sees a clean tail
  assign DIn = ((state_q == SERVE) && load && (RAddr < len_w))
             ? in_mem[RAddr[ADDR_W-1:0]] : 16'd0;

  assign out_data = out_valid ? out_mem[rd_ptr_q[ADDR_W-1:0]] : 16'd0;
  assign out_last = out_valid && (rd_ptr_q == len_m1);

  assign data_done = data_done_q;
  assign iir_rst   = iir_rst_q;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    data_done_d = data_done_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          fill_cnt_d = fill_cnt_q + ONE;
          if (in_last || (fill_cnt_q == LAST_IDX)) begin
            len_d   = fill_cnt_q + ONE;
            state_d = SERVE;
          end
        end
      end
      SERVE: begin
        if (data_done_q && Finish) begin
          state_d     = DRAIN;
          data_done_d = 1'b0;
        end else if (last_wr) begin
          data_done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (beat) begin
          rd_ptr_d = rd_ptr_q + ONE;
          if (out_last) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            rd_ptr_d   = '0;
            len_d      = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
    // Filter runs only while the block is being served
    iir_rst_d = (state_d != SERVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      data_done_q <= 1'b0;
      iir_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      data_done_q <= data_done_d;
      iir_rst_q   <= iir_rst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      in_mem[fill_cnt_q[ADDR_W-1:0]] <= in_data;
    if (wr_ok)
      out_mem[WAddr[ADDR_W-1:0]] <= Yn;
  end

endmodule

// File: tb/tb_iir_stream_host.sv
// Bench for iir_stream_host: directed block flows, read table,
// small-depth overflow case and randomized blocks against a reference model.
module tb_iir_stream_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 0, in_last = 0, load = 0, WEN = 0;
  logic        Finish = 0, out_ready = 0;
  logic [15:0] in_data = '0, Yn = '0;
  logic [19:0] RAddr = '0, WAddr = '0;
  logic        in_ready, iir_rst, data_done, out_valid, out_last;
  logic [15:0] DIn, out_data;

  logic        s_in_valid = 0, s_in_last = 0, s_load = 0, s_WEN = 0;
  logic        s_Finish = 0, s_out_ready = 0;
  logic [15:0] s_in_data = '0, s_Yn = '0;
  logic [19:0] s_RAddr = '0, s_WAddr = '0;
  logic        s_in_ready, s_iir_rst, s_data_done, s_out_valid, s_out_last;
  logic [15:0] s_DIn, s_out_data;

  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] smp[$];
  logic [15:0] res[$];

  typedef struct {
    logic        ld;
    logic [19:0] ra;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t rtab[7];

  always #5 clk = ~clk;

  iir_stream_host #(.ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .iir_rst(iir_rst),
    .load(load), .RAddr(RAddr), .DIn(DIn),
    .WEN(WEN), .WAddr(WAddr), .Yn(Yn),
    .data_done(data_done), .Finish(Finish),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  iir_stream_host #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last),
    .in_ready(s_in_ready), .iir_rst(s_iir_rst),
    .load(s_load), .RAddr(s_RAddr), .DIn(s_DIn),
    .WEN(s_WEN), .WAddr(s_WAddr), .Yn(s_Yn),
    .data_done(s_data_done), .Finish(s_Finish),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last),
    .out_ready(s_out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic send_block(input int n, input bit gaps);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 5000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = smp[i];
      in_last  = (i == n - 1);
      if (in_valid && in_ready) i++;
      tick();
      cyc++;
    end
    in_valid = 0;
    in_last  = 0;
    if (i < n) fail_now("send_block");
    chk("fill_ready_low", in_ready, 0);
    chk("fill_iir_rst_low", iir_rst, 0);
  endtask

  task automatic check_reads(input int n);
    for (int a = 0; a < n; a++) begin
      load  = 1;
      RAddr = 20'(a);
      #1;
      chk("rd_din", DIn, smp[a]);
    end
    RAddr = 20'(n + $urandom_range(0, 50));
    #1;
    chk("rd_oob", DIn, 0);
    load = 0;
  endtask

  task automatic write_results(input int n, input bit noise);
    if (noise) begin
      WEN = 1;
      WAddr = 20'(n + $urandom_range(0, 9));
      Yn = 16'hDEAD;
      tick();
      if (n > 1) begin
        WAddr = 0;
        Yn = 16'hBEEF;
        tick();
      end
    end
    for (int a = 0; a < n; a++) begin
      WEN = 1;
      WAddr = 20'(a);
      Yn = res[a];
      if (a == n - 1) chk("done_before_last", data_done, 0);
      tick();
      if (noise && $urandom_range(0, 3) == 0) begin
        WEN = 0;
        tick();
      end
    end
    WEN = 0;
    chk("done_after_last", data_done, 1);
  endtask

  task automatic do_finish(input int idle);
    for (int k = 0; k < idle; k++) begin
      tick();
      chk("done_hold", data_done, 1);
    end
    Finish = 1;
    tick();
    Finish = 0;
    chk("drain_valid", out_valid, 1);
    chk("drain_iir_rst", iir_rst, 1);
    chk("drain_done_clr", data_done, 0);
  endtask

  // mode 0: ready always, 1: 1,0,0,1 repeating, 2: random
  task automatic drain(input int n, input int mode);
    int idx;
    int cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 20 * n + 20) begin
      unique case (mode)
        0: out_ready = 1;
        1: out_ready = pat[3 - (cyc % 4)];
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      chk("drain_vld", out_valid, 1);
      chk("never_both", in_ready & out_valid, 0);
      chk("drain_data", out_data, res[idx]);
      chk("drain_last", out_last, (idx == n - 1));
      if (out_ready) idx++;
      tick();
      cyc++;
    end
    out_ready = 0;
    if (idx < n) fail_now("drain");
    chk("post_drain_ready", in_ready, 1);
    chk("post_drain_vld", out_valid, 0);
  endtask

  initial begin
    rtab[0] = '{1'b1, 20'd0, 16'h0100};
    rtab[1] = '{1'b1, 20'd1, 16'h0200};
    rtab[2] = '{1'b1, 20'd2, 16'hFF00};
    rtab[3] = '{1'b1, 20'd3, 16'h0000};
    rtab[4] = '{1'b1, 20'd4, 16'h0000};
    rtab[5] = '{1'b0, 20'd2, 16'h0000};
    rtab[6] = '{1'b1, 20'hFFFFF, 16'h0000};

    load = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_iir_rst", iir_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    rst = 0;
    tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_iir_rst", iir_rst, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_last", out_last, 0);
    chk("idle_out_data", out_data, 0);
    chk("idle_done", data_done, 0);
    chk("idle_din", DIn, 0);
    load = 0;

    // directed 4-sample block
    smp = '{16'h0100, 16'h0200, 16'hFF00, 16'h0000};
    res = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_block(4, 0);
    foreach (rtab[i]) begin
      load  = rtab[i].ld;
      RAddr = rtab[i].ra;
      #1;
      chk($sformatf("tab_din_%0d", i), DIn, rtab[i].exp);
    end
    load = 0;
    for (int a = 0; a < 3; a++) begin
      WEN = 1; WAddr = 20'(a); Yn = res[a];
      tick();
    end
    WAddr = 7; Yn = 16'h7777;
    tick();
    WEN = 0;
    chk("stray_no_done", data_done, 0);
    Finish = 1;
    tick();
    Finish = 0;
    chk("finish_ignored", out_valid, 0);
    chk("finish_ign_rst", iir_rst, 0);
    WEN = 1; WAddr = 3; Yn = res[3];
    tick();
    WEN = 0;
    chk("done_after_w3", data_done, 1);
    do_finish(1);
    drain(4, 0);

    // same block, stalled drain
    smp = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    res = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    send_block(4, 0);
    write_results(4, 0);
    do_finish(0);
    drain(4, 1);

    // small depth: block closes at DEPTH without in_last
    s_in_valid = 1;
    s_in_last  = 0;
    for (int i = 0; i < 4; i++) begin
      s_in_data = 16'h0A00 + 16'(i);
      chk("s_fill_ready", s_in_ready, 1);
      tick();
    end
    s_in_data = 16'h0A04;
    chk("s_full_ready", s_in_ready, 0);
    chk("s_full_iir_rst", s_iir_rst, 0);
    tick();
    chk("s_fifth_blocked", s_in_ready, 0);
    s_in_valid = 0;
    s_load = 1;
    s_RAddr = 3;
    #1;
    chk("s_din3", s_DIn, 16'h0A03);
    s_RAddr = 4;
    #1;
    chk("s_din4_oob", s_DIn, 0);
    s_load = 0;
    for (int a = 0; a < 4; a++) begin
      s_WEN = 1; s_WAddr = 20'(a); s_Yn = 16'h0B00 + 16'(a);
      tick();
    end
    s_WEN = 0;
    chk("s_done", s_data_done, 1);
    s_Finish = 1;
    tick();
    s_Finish = 0;
    s_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("s_out_data", s_out_data, 16'h0B00 + 16'(i));
      chk("s_out_last", s_out_last, (i == 3));
      tick();
    end
    s_out_ready = 0;
    chk("s_back_fill", s_in_ready, 1);
    s_in_valid = 1; s_in_data = 16'h0A04; s_in_last = 1;
    tick();
    s_in_valid = 0; s_in_last = 0;
    chk("s_one_serve", s_in_ready, 0);
    s_load = 1; s_RAddr = 0;
    #1;
    chk("s_new_din0", s_DIn, 16'h0A04);
    s_RAddr = 1;
    #1;
    chk("s_new_din1_oob", s_DIn, 0);
    s_load = 0;

    // reset in the middle of SERVE
    smp = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    send_block(4, 0);
    for (int a = 0; a < 2; a++) begin
      WEN = 1; WAddr = 20'(a); Yn = 16'h5500;
      tick();
    end
    WEN = 0;
    rst = 1;
    #1;
    chk("mid_rst_iir_rst", iir_rst, 1);
    chk("mid_rst_done", data_done, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_vld", out_valid, 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_vld", out_valid, 0);
    smp = '{16'h0ABC};
    res = '{16'hABCD};
    send_block(1, 0);
    check_reads(1);
    write_results(1, 0);
    do_finish(0);
    drain(1, 0);

    // randomized blocks
    for (int b = 0; b < 30; b++) begin
      int n;
      n = $urandom_range(1, 40);
      smp.delete();
      res.delete();
      for (int i = 0; i < n; i++) begin
        smp.push_back(16'($urandom));
        res.push_back(16'($urandom));
      end
      send_block(n, 1);
      check_reads(n);
      write_results(n, 1);
      do_finish($urandom_range(0, 2));
      drain(n, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_stream_host.md
# iir_stream_host

Memory-side host for the IIR filter core. Buffers an input sample block from an upstream valid/ready stream and serves it to the filter's read port (`RAddr`/`load`/`DIn`). Captures filter results from its write port (`WEN`/`WAddr`/`Yn`), signals `data_done`, and streams the result block downstream. It holds the filter in reset while filling and draining, so each block starts from zero filter state.

## Interface
- `ADDR_W`, 10: buffer address width; `DEPTH = 2**ADDR_W` samples per block (max).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream sample valid.
- `in_data` in 16: signed input sample.
- `in_last` in 1: marks final sample of block.
- `in_ready` out 1: host accepts sample.
- `iir_rst` out 1: reset to filter, registered, active-high.
- `load` in 1: filter read enable.
- `RAddr` in 20: filter read address.
- `DIn` out 16: sample at `RAddr` (combinational).
- `WEN` in 1: filter write enable.
- `WAddr` in 20: filter write address.
- `Yn` in 16: filter result.
- `data_done` out 1: all results captured (registered).
- `Finish` in 1: filter acknowledges `data_done`.
- `out_valid` out 1: result valid.
- `out_data` out 16: result sample.
- `out_last` out 1: final result of block.
- `out_ready` in 1: downstream accepts result.

## Operation
- There are three states.
- **FILL**:
  - `in_ready`=1.
  - Each `in_valid&&in_ready` writes `in_data` to `in_mem[fill_cnt]` and increments `fill_cnt`.
  - Block ends on an accepted `in_last`, or when the DEPTH-th sample is accepted (`in_last` implied). `len` = count of accepted samples (1..DEPTH, ADDR_W+1 bits).
  - Then go to SERVE.
- **SERVE**:
  - `in_ready`=0.
  - `DIn` = `in_mem[RAddr]` when `load`=1 and `RAddr<len`, else 16'd0.
  - On `WEN`=1 and `WAddr<len`, `Yn` is written to `out_mem[WAddr]`. Writes with `WAddr>=len` are ignored.
  - The write with `WAddr==len-1` sets `data_done`=1 from the next cycle; it holds until state leaves SERVE.
  - `Finish`=1 while `data_done`=1 moves the state to DRAIN. `Finish` is ignored while `data_done`=0.
- **DRAIN**:
  - `out_valid`=1.
  - `out_data`=`out_mem[rd_ptr]`; `out_last`=(`rd_ptr==len-1`).
  - `rd_ptr` advances on `out_valid&&out_ready`. `out_data`/`out_last` are stable while stalled.
  - The accepted `out_last` beat returns the state to FILL with `fill_cnt`, `rd_ptr`, `len` cleared.
- **iir_rst**: registered copy of (next_state != SERVE). It is 1 in FILL and DRAIN and 0 throughout SERVE.
- **Reset**:
  - State FILL, `fill_cnt`/`len`/`rd_ptr`=0, `data_done`=0, `iir_rst`=1.
  - Outputs during/after reset: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `DIn`=0.
  - Memories are not cleared.
  - Reset mid-block discards the block; any partial input/output is lost, with no residual `out_valid`.

## Timing
- Sample accepted with `in_last` at edge t: state=SERVE and `iir_rst`=0 from t+1. The filter presents `RAddr`=0 in cycle t+1.
- `DIn` is combinational from `RAddr` with zero latency; the filter samples it on the same edge.
- Write with `WAddr==len-1` at edge w: `data_done`=1 in cycle w+1. The filter raises `Finish` at w+2.
- `Finish` sampled high at edge f: in cycle f+1, state=DRAIN, `iir_rst`=1, `data_done`=0, `out_valid`=1.
- DRAIN throughput is one beat/cycle with `out_ready` held high. There is one cycle between the last accepted beat and the next `in_ready`=1 (state FILL).
- `in_ready` and `out_valid` are never both 1.

## Test plan
- Reset then idle: after `rst` release, `in_ready`=1, `iir_rst`=1, `out_valid`=0, `data_done`=0, `DIn`=0.
- Block of 4 samples 16'h0100,16'h0200,16'hFF00,16'h0000 with `in_last` on the 4th:
  - `in_ready` drops next cycle; `iir_rst`=0.
  - With `RAddr`=2 and `load`=1, `DIn`=16'hFF00.
  - With `RAddr`=4, `DIn`=0.
- Filter model writes `Yn`=16'h1111,16'h2222,16'h3333,16'h4444 to `WAddr` 0..3, plus a stray write to `WAddr`=7:
  - `data_done`=1 one cycle after `WAddr`=3.
  - Stray write is ignored.
  - `Finish` gives DRAIN outputs 1111,2222,3333,4444 with `out_last` on 4444; then `in_ready`=1.
- DRAIN with `out_ready` toggling 1,0,0,1: `out_data` holds during stall; no beat is lost or duplicated.
- ADDR_W=2, 4 samples without `in_last`: block closes at 4 (`len`=4); the 5th `in_valid` is not accepted until the next FILL.
- `rst` pulsed mid-SERVE after 2 of 4 writes:
  - Immediately `iir_rst`=1, `data_done`=0, state FILL.
  - A new 1-sample block completes normally with `out_last` on the first beat.
